// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared state encodings and defaults for the period meter.
`timescale 1ns/1ps
package period_meter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEAS = 2'd1,
        ST_OVF  = 2'd2
    } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchronizer for an asynchronous input plus a
// rising-edge pulse on the synchronized level.
`timescale 1ns/1ps
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2  // must be at least 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;

    // Shift the raw input through the synchronizer, then keep one delayed copy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
            r_s_d  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign s    = r_sync[SYNC_STAGES-1];
    assign rise = r_sync[SYNC_STAGES-1] & ~r_s_d;

endmodule

// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow asynchronous waveform
// in clk cycles. A report needs two consecutive rising edges both seen while
// measuring; a period longer than the counter range sets a sticky overflow.
`timescale 1ns/1ps
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic w_s;
    logic w_rise;

    state_e           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_hcnt;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_high_time;
    logic             r_valid;
    logic             r_overflow;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (sig_in),
        .s    (w_s),
        .rise (w_rise)
    );

    // FSM, period/high-time counters and registered report outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_hcnt      <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_rise) begin
                // Every edge restarts counting; only an edge seen in MEAS closes
                // a complete period, so IDLE/OVF edges merely arm.
                r_cnt   <= CNT_ONE;
                r_hcnt  <= CNT_ONE;
                r_state <= ST_MEAS;
                if (r_state == ST_MEAS) begin
                    r_period    <= r_cnt;
                    r_high_time <= r_hcnt;
                    r_valid     <= 1'b1;
                    r_overflow  <= 1'b0;
                end
            end else if (r_state == ST_MEAS) begin
                if (r_cnt == CNT_MAX) begin
                    // Counter would wrap: give up on this period.
                    r_state    <= ST_OVF;
                    r_overflow <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
                if (w_s && (r_hcnt != CNT_MAX)) begin
                    r_hcnt <= r_hcnt + CNT_ONE;
                end
            end
        end
    end

    assign period    = r_period;
    assign high_time = r_high_time;
    assign valid     = r_valid;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed tests for period_meter with WIDTH=8, SYNC_STAGES=2
// and a 62.5 ns clock.
`timescale 1ns/1ps
module tb_period_meter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned SYNC  = 2;

    logic             clk    = 1'b0;
    logic             reset  = 1'b0;
    logic             sig_in = 1'b0;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             valid;
    logic             overflow;

    period_meter #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sig_in   (sig_in),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .overflow (overflow)
    );

    always #31.25 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   ovf_cyc  = -1;
    logic prev_ovf = 1'b0;
    int   q_per[$];
    int   q_ht[$];
    int   q_cyc[$];
    logic q_ovf[$];

    // One clk cycle: drive sig_in just after posedge, sample outputs at negedge.
    task automatic tick(input logic v);
        sig_in = v;
        @(negedge clk);
        if (valid) begin
            q_per.push_back(int'(period));
            q_ht.push_back(int'(high_time));
            q_cyc.push_back(cyc);
            q_ovf.push_back(overflow);
        end
        if (overflow && !prev_ovf) ovf_cyc = cyc;
        prev_ovf = overflow;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < hi; i++) tick(1'b1);
            for (int i = 0; i < lo; i++) tick(1'b0);
        end
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic clear_q();
        q_per.delete();
        q_ht.delete();
        q_cyc.delete();
        q_ovf.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(1'b0);
        tick(1'b0);
        reset = 1'b1;
        tick(1'b0);
        tick(1'b0);
        clear_q();
        ovf_cyc = -1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sig_in = (i % 3) != 0;
            @(negedge clk);
            n_checks++;
            if ({period, high_time, valid, overflow} !== 18'd0)
                $display("FAIL reset_hold cyc=%0d got per=%0d ht=%0d v=%b ovf=%b want all 0",
                         i, period, high_time, valid, overflow);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(i[0]);
            n_checks++;
            if ({period, high_time, valid, overflow} !== 18'd0)
                $display("FAIL reset_release cyc=%0d got per=%0d ht=%0d v=%b ovf=%b want all 0",
                         i, period, high_time, valid, overflow);
            else n_pass++;
        end
        flush(4);
    endtask

    task automatic test_square();
        int c0;
        do_reset();
        c0 = cyc;
        wave(5, 5, 4);
        flush(6);
        n_checks++;
        if (q_per.size() != 3)
            $display("FAIL square_count got %0d want 3", q_per.size());
        else n_pass++;
        if (q_per.size() == 3) begin
            n_checks++;
            if (q_cyc[0] - c0 != 13)
                $display("FAIL square_latency got %0d want 13", q_cyc[0] - c0);
            else n_pass++;
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (q_per[i] != 10 || q_ht[i] != 5 || q_ovf[i] !== 1'b0)
                    $display("FAIL square_report[%0d] got per=%0d ht=%0d ovf=%b want 10/5/0",
                             i, q_per[i], q_ht[i], q_ovf[i]);
                else n_pass++;
                if (i > 0) begin
                    n_checks++;
                    if (q_cyc[i] - q_cyc[i-1] != 10)
                        $display("FAIL square_spacing[%0d] got %0d want 10",
                                 i, q_cyc[i] - q_cyc[i-1]);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_duty();
        do_reset();
        wave(3, 7, 3);
        flush(6);
        n_checks++;
        if (q_per.size() != 2)
            $display("FAIL duty_count got %0d want 2", q_per.size());
        else n_pass++;
        for (int i = 0; i < q_per.size(); i++) begin
            n_checks++;
            if (q_per[i] != 10 || q_ht[i] != 3)
                $display("FAIL duty_report[%0d] got per=%0d ht=%0d want 10/3",
                         i, q_per[i], q_ht[i]);
            else n_pass++;
        end
    endtask

    task automatic test_toggle();
        do_reset();
        wave(1, 1, 6);
        flush(6);
        n_checks++;
        if (q_per.size() != 5)
            $display("FAIL toggle_count got %0d want 5", q_per.size());
        else n_pass++;
        for (int i = 0; i < q_per.size(); i++) begin
            n_checks++;
            if (q_per[i] != 2 || q_ht[i] != 1)
                $display("FAIL toggle_report[%0d] got per=%0d ht=%0d want 2/1",
                         i, q_per[i], q_ht[i]);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        do_reset();
        wave(100, 155, 3);
        for (int i = 0; i < 300; i++) tick(1'b0);
        n_checks++;
        if (q_per.size() != 2)
            $display("FAIL ovf_p255_count got %0d want 2", q_per.size());
        else n_pass++;
        for (int i = 0; i < q_per.size(); i++) begin
            n_checks++;
            if (q_per[i] != 255 || q_ht[i] != 100 || q_ovf[i] !== 1'b0)
                $display("FAIL ovf_p255_report[%0d] got per=%0d ht=%0d ovf=%b want 255/100/0",
                         i, q_per[i], q_ht[i], q_ovf[i]);
            else n_pass++;
        end
        n_checks++;
        if (overflow !== 1'b1)
            $display("FAIL ovf_set got %b want 1", overflow);
        else n_pass++;
        if (q_cyc.size() > 0) begin
            n_checks++;
            if (ovf_cyc - q_cyc[q_cyc.size()-1] != 255)
                $display("FAIL ovf_delay got %0d want 255", ovf_cyc - q_cyc[q_cyc.size()-1]);
            else n_pass++;
        end
        clear_q();
        wave(1, 19, 1);
        n_checks++;
        if (q_per.size() != 0 || overflow !== 1'b1 || period !== 8'd255)
            $display("FAIL ovf_rearm got valids=%0d ovf=%b per=%0d want 0/1/255",
                     q_per.size(), overflow, period);
        else n_pass++;
        wave(1, 19, 1);
        flush(6);
        n_checks++;
        if (q_per.size() != 1)
            $display("FAIL ovf_recover_count got %0d want 1", q_per.size());
        else n_pass++;
        if (q_per.size() == 1) begin
            n_checks++;
            if (q_per[0] != 20 || q_ht[0] != 1 || q_ovf[0] !== 1'b0)
                $display("FAIL ovf_recover_report got per=%0d ht=%0d ovf=%b want 20/1/0",
                         q_per[0], q_ht[0], q_ovf[0]);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        wave(5, 5, 3);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        n_checks++;
        if (period !== 8'd10)
            $display("FAIL midrst_pre got per=%0d want 10", period);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({period, high_time, valid, overflow} !== 18'd0)
            $display("FAIL midrst_async got per=%0d ht=%0d v=%b ovf=%b want all 0",
                     period, high_time, valid, overflow);
        else n_pass++;
        tick(1'b0);
        tick(1'b0);
        reset = 1'b1;
        clear_q();
        wave(5, 5, 2);
        flush(6);
        n_checks++;
        if (q_per.size() != 1)
            $display("FAIL midrst_count got %0d want 1", q_per.size());
        else n_pass++;
        if (q_per.size() == 1) begin
            n_checks++;
            if (q_per[0] != 10 || q_ht[0] != 5)
                $display("FAIL midrst_report got per=%0d ht=%0d want 10/5", q_per[0], q_ht[0]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_square();
        test_duty();
        test_toggle();
        test_overflow();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period and high time of a slow, asynchronous digital waveform, such as the output of the `divider` block, in units of the system clock. It is the receive-side counterpart of `divider`: `divider` turns a ratio into a waveform, and `period_meter` turns a waveform back into a cycle count. It sits beside `divider` in the 16 MHz (62.5 ns) clock domain and feeds self-check logic or a status register.

## Interface
- `WIDTH`, default 8: width of the period and high-time counters and outputs.
- `SYNC_STAGES`, default 2: number of synchronizer flops on `sig_in`. Minimum 2.

Ports:
- `clk`  in  1: system clock. Rising edge active.
- `reset`  in  1: asynchronous, active-low reset. Asserting it (low) clears all state immediately.
- `sig_in`  in  1: waveform to measure. Asynchronous to `clk`.
- `period`  out  WIDTH: last measured period, in clk cycles.
- `high_time`  out  WIDTH: clk cycles `sig_in` was high during that period.
- `valid`  out  1: one-cycle strobe. Asserted when `period` and `high_time` update.
- `overflow`  out  1: sticky flag. Set when a period exceeds 2^WIDTH-1.

## Operation
- `sig_in` passes through `SYNC_STAGES` flops, giving `s`. A further flop holds `s_d`. The rise pulse is `rise = s & ~s_d`.
- States:
  - IDLE: entered on reset. On `rise`, go to MEAS.
  - MEAS: counting. On `rise`, report the measurement and stay in MEAS. If `cnt` = 2^WIDTH-1 with no `rise`, go to OVF.
  - OVF: the counter has saturated. On `rise`, go to MEAS with no report.
- Counter `cnt`:
  - Loads 1 on every `rise`.
  - Otherwise increments in MEAS.
  - Holds in IDLE and OVF.
- Counter `hcnt`:
  - Loads 1 on `rise`.
  - Otherwise increments in MEAS when `s` = 1, saturating at 2^WIDTH-1.
- Reporting, on `rise` in MEAS (registered):
  - `period` <= `cnt`
  - `high_time` <= `hcnt`
  - `valid` <= 1
  - `overflow` <= 0
- `valid` is 0 in every other cycle.
- When MEAS moves to OVF, `overflow` <= 1. It stays set until the next report.
- `period` and `high_time` hold their last reported values between reports.
- The first `rise` after reset or after OVF only arms the measurement. A report needs two consecutive edges, both seen in MEAS.
- `high_time` ≤ `period` always holds.
- Shortest measurable period is 2, for example toggling every cycle.
- Reset: all outputs 0, state IDLE, counters 0, synchronizer flops 0.

## Timing
- Latency: `valid` is high in the cycle after the clk edge at which `rise` is 1. That is `SYNC_STAGES`+1 clk edges after `sig_in` is first sampled high.
- For `sig_in` with period P cycles and high time H cycles, 2 ≤ P ≤ 2^WIDTH-1:
  - Report: `period` = P, `high_time` = H.
  - Cadence: one `valid` every P cycles once armed.
- Boundaries:
  - Edge at `cnt` = 2^WIDTH-1: reported as `period` = 2^WIDTH-1, no overflow.
  - No edge at `cnt` = 2^WIDTH-1: enters OVF on that clk edge.
  - `rise` in the same cycle `cnt` saturates: the edge wins, and a report is made.
  - Reset release: only sampled on a clk edge. No `valid` within `SYNC_STAGES`+2 cycles after release.
  - Reset mid-period: the partial measurement is discarded.

## Structure
- Package/header `period_meter_pkg`: state encodings ST_IDLE = 2'd0, ST_MEAS = 2'd1, ST_OVF = 2'd2, plus the default `WIDTH`.
- Sub-module `sync_edge_detect`:
  - Parameter: `SYNC_STAGES`.
  - Inputs: `clk`, `reset`, `d`.
  - Outputs: `s`, `rise`.
  - Reused by future input-capture blocks.
- Top level holds the FSM, the counters and the output registers.

## Test plan
Use a 62.5 ns clk and `WIDTH` = 8 throughout.
- Reset low for 1000 ns -> `period` = 0, `high_time` = 0, `valid` = 0 and `overflow` = 0 for the whole reset, and during 3 cycles after release.
- 50% square wave with P = 10 (5 high, 5 low) -> first edge gives no `valid`. Every later edge gives `valid` = 1 for one cycle with `period` = 10, `high_time` = 5, spaced 10 cycles apart.
- Waveform with 3 high and 7 low -> `period` = 10, `high_time` = 3.
- Toggle `sig_in` every cycle -> `period` = 2, `high_time` = 1 on each report.
- Waveform with P = 255 -> `period` = 255, `overflow` = 0. Then hold `sig_in` low for 300 cycles:
  - `overflow` = 1 after 255 counts.
  - The next edge gives no `valid`.
  - The following edge, 20 cycles later, gives `valid` with `period` = 20 and `overflow` = 0.
- P = 10 running, then `reset` pulsed low for 2 cycles mid-period -> all outputs 0 at once. The first edge after release gives no `valid`. The second edge reports `period` = 10.
